// File: rtl/term_pkg.sv
// Shared constants for the terminal UART transmit path.
// Holds the arbiter state encoding, ASCII control codes and default sizing.
package term_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_DONE  = 3'd2,
      GAP_WAIT   = 3'd3,
      LOCK_STALL = 3'd4
   } state_t;

   localparam logic [7:0] ASCII_ESC      = 8'h1B;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;

   localparam int NREQ_DEFAULT = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, mod NREQ.
// Ports: req (request vector), ptr (last served), onehot/idx (winner), valid.
module rr_pick
   import term_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!valid && req[j]) begin
            valid     = 1'b1;
            onehot[j] = 1'b1;
            idx       = PW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte sources, round-robin,
// with a packet lock so multi-byte sequences are never interleaved.
// Ports: clk, rst (sync, active-low); i_req_byte/i_req_v/i_req_last per
// requester, o_req_ack pulse on consume; o_grant one-hot owner;
// o_byte/o_byte_v to UART; i_tx_active/i_tx_done from UART;
// o_busy (not idle); o_err pulse on timeout abort.
module uart_tx_arbiter
   import term_pkg::*;
#(
   parameter int NREQ    = NREQ_DEFAULT,
   parameter int TIMEOUT = 100000,
   parameter int GAP     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ*8-1:0] i_req_byte,
   input  logic [NREQ-1:0]   i_req_v,
   input  logic [NREQ-1:0]   i_req_last,
   output logic [NREQ-1:0]   o_req_ack,
   output logic [NREQ-1:0]   o_grant,
   output logic [7:0]        o_byte,
   output logic              o_byte_v,
   input  logic              i_tx_active,
   input  logic              i_tx_done,
   output logic              o_busy,
   output logic              o_err
);

   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   // Abort fires on the edge the timer would reach TIMEOUT.
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   own;
   logic            last_q;
   logic [TW-1:0]   timer;
   logic [GW-1:0]   gap_cnt;

   logic [NREQ-1:0] pick_hot;
   logic [PW-1:0]   pick_idx;
   logic            pick_v;

   logic [7:0]      own_byte;
   logic            own_v;
   logic            own_last;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (i_req_v),
      .ptr    (ptr),
      .onehot (pick_hot),
      .idx    (pick_idx),
      .valid  (pick_v)
   );

   assign own_byte = i_req_byte[8*int'(own) +: 8];
   assign own_v    = i_req_v[own];
   assign own_last = i_req_last[own];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= PTR_RST;
         own       <= '0;
         last_q    <= 1'b0;
         timer     <= '0;
         gap_cnt   <= '0;
         o_req_ack <= '0;
         o_grant   <= '0;
         o_byte    <= '0;
         o_byte_v  <= 1'b0;
         o_busy    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_byte_v  <= 1'b0;
         o_req_ack <= '0;
         o_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_v) begin
                  o_grant <= pick_hot;
                  own     <= pick_idx;
                  o_busy  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!own_v) begin
                  timer <= '0;
                  state <= LOCK_STALL;
               end else if (!i_tx_active) begin
                  o_byte    <= own_byte;
                  o_byte_v  <= 1'b1;
                  o_req_ack <= o_grant;
                  last_q    <= own_last;
                  timer     <= '0;
                  state     <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // A done in the strobe cycle belongs to the previous byte.
               if (i_tx_done && !o_byte_v) begin
                  if (GAP > 0) begin
                     gap_cnt <= '0;
                     state   <= GAP_WAIT;
                  end else if (last_q) begin
                     ptr     <= own;
                     o_grant <= '0;
                     o_busy  <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state <= ISSUE;
                  end
               end else if (timer == T_LAST) begin
                  o_err   <= 1'b1;
                  ptr     <= own;
                  o_grant <= '0;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            GAP_WAIT: begin
               if (gap_cnt == G_LAST) begin
                  if (last_q) begin
                     ptr     <= own;
                     o_grant <= '0;
                     o_busy  <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state <= ISSUE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            LOCK_STALL: begin
               // Grant is held so nobody can interleave into the packet.
               if (own_v) begin
                  state <= ISSUE;
               end else if (timer == T_LAST) begin
                  o_err   <= 1'b1;
                  ptr     <= own;
                  o_grant <= '0;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               o_grant <= '0;
               o_busy  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=3, TIMEOUT=16, GAP=0).
// Ports: none; drives the DUT from initial-block stimulus.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] i_req_byte;
   logic [2:0]  i_req_v;
   logic [2:0]  i_req_last;
   logic [2:0]  o_req_ack;
   logic [2:0]  o_grant;
   logic [7:0]  o_byte;
   logic        o_byte_v;
   logic        i_tx_active;
   logic        i_tx_done;
   logic        o_busy;
   logic        o_err;

   int errs   = 0;
   int checks = 0;

   uart_tx_arbiter #(
      .NREQ    (3),
      .TIMEOUT (16),
      .GAP     (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_byte  (i_req_byte),
      .i_req_v     (i_req_v),
      .i_req_last  (i_req_last),
      .o_req_ack   (o_req_ack),
      .o_grant     (o_grant),
      .o_byte      (o_byte),
      .o_byte_v    (o_byte_v),
      .i_tx_active (i_tx_active),
      .i_tx_done   (i_tx_done),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] v;
      logic [2:0] last;
      logic       act;
      logic       done;
      logic [2:0] grant;
      logic       bv;
      logic [7:0] byt;
      logic [2:0] ack;
      logic       busy;
      logic       err;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(logic [2:0] v, logic act, logic done,
                               logic [2:0] g, logic bv, logic [7:0] b,
                               logic [2:0] a, logic busy);
      vec_t r;
      r.v = v; r.last = 3'b111; r.act = act; r.done = done;
      r.grant = g; r.bv = bv; r.byt = b; r.ack = a;
      r.busy = busy; r.err = 1'b0;
      return r;
   endfunction

   function automatic logic [16:0] outs();
      return {o_grant, o_byte_v, o_byte, o_req_ack, o_busy, o_err};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b0;
      i_req_v     = '0;
      i_req_last  = '0;
      i_req_byte  = '0;
      i_tx_active = 1'b0;
      i_tx_done   = 1'b0;
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'h0);
      rst = 1'b1;
   endtask

   task automatic wait_strobe(string name);
      int n = 0;
      while (!o_byte_v && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_byte_v) chk(name, 32'(o_byte_v), 32'h1);
   endtask

   initial begin
      logic [7:0] seq[$];
      logic [2:0] gq[$];
      logic [7:0] pkt[3];
      logic [7:0] exp_b[5];
      logic [2:0] exp_g[5];
      int idx2, cd, cnt, bad;

      // Inputs before edge | outputs after edge. Bytes: r0=41 r1=42 r2=43.
      tbl[0]  = mk(3'b000, 0, 0, 3'b000, 0, 8'h00, 3'b000, 0);
      tbl[1]  = mk(3'b001, 0, 0, 3'b001, 0, 8'h00, 3'b000, 1);
      tbl[2]  = mk(3'b001, 0, 0, 3'b001, 1, 8'h41, 3'b001, 1);
      tbl[3]  = mk(3'b000, 0, 0, 3'b001, 0, 8'h41, 3'b000, 1);
      tbl[4]  = mk(3'b000, 0, 1, 3'b000, 0, 8'h41, 3'b000, 0);
      tbl[5]  = mk(3'b111, 0, 0, 3'b010, 0, 8'h41, 3'b000, 1);
      tbl[6]  = mk(3'b111, 0, 0, 3'b010, 1, 8'h42, 3'b010, 1);
      tbl[7]  = mk(3'b111, 0, 0, 3'b010, 0, 8'h42, 3'b000, 1);
      tbl[8]  = mk(3'b111, 0, 1, 3'b000, 0, 8'h42, 3'b000, 0);
      tbl[9]  = mk(3'b111, 0, 0, 3'b100, 0, 8'h42, 3'b000, 1);
      tbl[10] = mk(3'b111, 0, 0, 3'b100, 1, 8'h43, 3'b100, 1);
      tbl[11] = mk(3'b111, 0, 1, 3'b100, 0, 8'h43, 3'b000, 1);
      tbl[12] = mk(3'b111, 0, 1, 3'b000, 0, 8'h43, 3'b000, 0);
      tbl[13] = mk(3'b111, 0, 0, 3'b001, 0, 8'h43, 3'b000, 1);
      tbl[14] = mk(3'b111, 0, 0, 3'b001, 1, 8'h41, 3'b001, 1);
      tbl[15] = mk(3'b111, 0, 0, 3'b001, 0, 8'h41, 3'b000, 1);
      tbl[16] = mk(3'b111, 0, 1, 3'b000, 0, 8'h41, 3'b000, 0);
      tbl[17] = mk(3'b111, 0, 0, 3'b010, 0, 8'h41, 3'b000, 1);
      tbl[18] = mk(3'b111, 1, 0, 3'b010, 0, 8'h41, 3'b000, 1);
      tbl[19] = mk(3'b111, 1, 0, 3'b010, 0, 8'h41, 3'b000, 1);
      tbl[20] = mk(3'b111, 0, 0, 3'b010, 1, 8'h42, 3'b010, 1);
      tbl[21] = mk(3'b111, 1, 0, 3'b010, 0, 8'h42, 3'b000, 1);
      tbl[22] = mk(3'b111, 0, 1, 3'b000, 0, 8'h42, 3'b000, 0);

      i_req_byte = '0; i_req_v = '0; i_req_last = '0;
      i_tx_active = 1'b0; i_tx_done = 1'b0;

      do_reset();
      i_req_byte = {8'h43, 8'h42, 8'h41};
      for (int i = 0; i < 23; i++) begin
         i_req_v     = tbl[i].v;
         i_req_last  = tbl[i].last;
         i_tx_active = tbl[i].act;
         i_tx_done   = tbl[i].done;
         @(negedge clk);
         chk($sformatf("row%0d", i), 32'(outs()),
             32'({tbl[i].grant, tbl[i].bv, tbl[i].byt, tbl[i].ack,
                  tbl[i].busy, tbl[i].err}));
      end

      // Packet lock: req2 sends ESC [ H while 0 and 1 keep requesting.
      do_reset();
      pkt = '{8'h1B, 8'h5B, 8'h48};
      exp_b = '{8'h1B, 8'h5B, 8'h48, 8'h41, 8'h42};
      exp_g = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
      i_req_byte = {8'h1B, 8'h42, 8'h41};
      i_req_last = 3'b011;
      i_req_v    = 3'b100;
      idx2 = 0; cd = 0;
      for (int c = 0; c < 300 && seq.size() < 5; c++) begin
         @(negedge clk);
         i_tx_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) i_tx_done = 1'b1;
         end
         if (o_byte_v) begin
            seq.push_back(o_byte);
            gq.push_back(o_grant);
            cd = 3;
         end
         if (o_req_ack[2]) begin
            idx2++;
            if (idx2 >= 3) i_req_v[2] = 1'b0;
            else begin
               i_req_byte[23:16] = pkt[idx2];
               i_req_last[2] = (idx2 == 2);
            end
         end
         if (o_grant != 3'b000) i_req_v[1:0] = 2'b11;
      end
      chk("lock_count", 32'(seq.size()), 32'd5);
      for (int i = 0; i < 5 && i < seq.size(); i++) begin
         chk($sformatf("lock_byte%0d", i), 32'(seq[i]), 32'(exp_b[i]));
         chk($sformatf("lock_grant%0d", i), 32'(gq[i]), 32'(exp_g[i]));
      end

      // Backpressure: UART busy for 50 cycles, then one strobe.
      do_reset();
      i_req_byte = {8'h43, 8'h42, 8'h41};
      i_req_last = 3'b111;
      i_req_v = 3'b001;
      i_tx_active = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (o_byte_v) bad++;
      end
      chk("bp_no_strobe", 32'(bad), 32'd0);
      chk("bp_grant", 32'(o_grant), 32'h1);
      i_tx_active = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (o_byte_v) begin
            cnt++;
            i_req_v = 3'b000;
         end
      end
      chk("bp_one_strobe", 32'(cnt), 32'd1);

      // WAIT_DONE timeout: no tx_done ever arrives.
      do_reset();
      i_req_byte = {8'h43, 8'h42, 8'h41};
      i_req_last = 3'b011;
      i_req_v = 3'b011;
      wait_strobe("to_wait_strobe");
      chk("to_byte", 32'(o_byte), 32'h41);
      i_req_v = 3'b010;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!o_err && cnt < 40);
      chk("to_wait_cycles", 32'(cnt), 32'd16);
      chk("to_wait_grant0", 32'(o_grant), 32'h0);
      @(negedge clk);
      chk("to_err_pulse", 32'(o_err), 32'h0);
      chk("to_next_grant", 32'(o_grant), 32'h2);

      // LOCK_STALL timeout: req1 drops v mid-packet, req0 must stay blocked.
      do_reset();
      i_req_byte = {8'h43, 8'h11, 8'h41};
      i_req_last = 3'b000;
      i_req_v = 3'b010;
      wait_strobe("ls_strobe");
      i_req_v = 3'b001;
      @(negedge clk);
      i_tx_done = 1'b1;
      @(negedge clk);
      i_tx_done = 1'b0;
      cnt = 0; bad = 0;
      do begin
         @(negedge clk);
         cnt++;
         if (!o_err && (o_byte_v || o_grant != 3'b010)) bad++;
      end while (!o_err && cnt < 40);
      chk("ls_blocked", 32'(bad), 32'd0);
      chk("ls_err_seen", 32'(o_err), 32'h1);
      chk("ls_err_window", 32'(cnt >= 16 && cnt <= 18), 32'h1);
      @(negedge clk);
      chk("ls_next_grant", 32'(o_grant), 32'h1);

      // Reset in WAIT_DONE: everything clears, requester 0 first again.
      do_reset();
      i_req_byte = {8'h43, 8'h42, 8'h41};
      i_req_last = 3'b111;
      i_req_v = 3'b010;
      wait_strobe("rst_strobe");
      i_req_v = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_outs", 32'(outs()), 32'h0);
      rst = 1'b1;
      i_req_v = 3'b111;
      @(negedge clk);
      chk("rst_mid_grant", 32'(o_grant), 32'h1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NREQ byte sources: text-buffer refresh, cursor echo, escape-sequence generator.
- Round-robin arbitration, with a packet lock so multi-byte escape sequences are never interleaved.
- Issues one byte at a time, and waits for i_tx_done before the next.
- Sits between the terminal-buffer command engines and the UART TX.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TIMEOUT, 100000, cycles allowed in WAIT_DONE or LOCK_STALL before abort.
- GAP, 0, idle clocks inserted after each i_tx_done before the next byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- i_req_byte  in  NREQ*8  byte per requester; requester k uses bits [8k+7:8k].
- i_req_v  in  NREQ  requester k has a byte pending. Byte and last must be held stable until ack.
- i_req_last  in  NREQ  pending byte ends requester k's packet.
- o_req_ack  out  NREQ  one-cycle pulse: requester k's byte consumed.
- o_grant  out  NREQ  one-hot current owner; 0 when idle.
- o_byte  out  8  byte to UART TX.
- o_byte_v  out  1  one-cycle strobe to UART TX.
- i_tx_active  in  1  UART busy.
- i_tx_done  in  1  UART finished a byte (one-cycle pulse).
- o_busy  out  1  state != IDLE.
- o_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; all outputs 0.
  - rr pointer = NREQ-1, so requester 0 has first priority.
  - Timeout and gap counters = 0.
  - Reset mid-byte discards the packet; no ack is issued.
- All outputs are registered.
- IDLE:
  - If any i_req_v: pick the first set bit searching from ptr+1 upward, modulo NREQ.
  - Register o_grant = onehot(k); go ISSUE.
- ISSUE:
  - If i_req_v[k] and !i_tx_active:
    - o_byte <= byte[k]; o_byte_v <= 1; o_req_ack[k] <= 1 (both pulse one cycle).
    - Latch last = i_req_last[k]; clear timer; go WAIT_DONE.
  - If i_req_v[k] low: go LOCK_STALL.
  - If i_tx_active high: stay in ISSUE.
- Latency: i_req_v rising in IDLE gives o_byte_v 2 cycles later (IDLE then ISSUE).
- WAIT_DONE:
  - i_tx_done is ignored in the cycle o_byte_v is high.
  - On i_tx_done: go GAP_WAIT if GAP>0; otherwise apply the release rule below.
  - Timer reaching TIMEOUT: o_err pulse, ptr<=k, o_grant<=0, go IDLE.
- GAP_WAIT: count GAP cycles, then apply the release rule.
- Release rule:
  - If last: ptr<=k, o_grant<=0, go IDLE.
  - Otherwise keep the lock and go ISSUE with the same k.
- LOCK_STALL:
  - Grant held; other requesters are blocked.
  - i_req_v[k] returns: go ISSUE.
  - Timer reaching TIMEOUT: o_err, release as on a timeout abort, go IDLE.
- Boundary conditions:
  - Simultaneous requests are resolved purely by the rr pointer.
  - Single requester: it wins every time, with no bubble beyond IDLE.
  - A requester dropping i_req_v between packets loses nothing.
  - ptr wraps NREQ-1 to 0.
- Timer width: $clog2(TIMEOUT+1). Timer saturates; it does not wrap.

Decomposition:
- Package term_pkg holds:
  - State localparams: IDLE, ISSUE, WAIT_DONE, GAP_WAIT, LOCK_STALL (3-bit).
  - ASCII constants: ESC, '[', CR, LF.
  - Default NREQ.
- One combinational sub-module rr_pick (request vector, pointer) outputs a one-hot winner and a valid flag.
- Everything else stays in uart_tx_arbiter.

Test Plan:
- Single byte, idle UART:
  - Stimulus: req0 v=1, byte=0x41, last=1 at cycle 10.
  - Response: o_grant=001 at cycle 11; o_byte=0x41, o_byte_v and ack0 at cycle 12.
  - On i_tx_done at cycle 20: o_grant=0, IDLE at cycle 21.
- Round robin:
  - Stimulus: req0, req1, req2 all hold single-byte packets continuously.
  - Response: grant order is 0,1,2,0,1,2 and bytes appear in that order.
- Packet lock:
  - Stimulus: req2 sends ESC,'[','H' (last on 'H') while req0 and req1 request throughout.
  - Response: the three bytes go out contiguously, then grant moves to 0.
- Backpressure:
  - Stimulus: i_tx_active=1 for 50 cycles during ISSUE.
  - Response: no o_byte_v until active drops; then a single strobe.
- Timeout (TIMEOUT=16):
  - WAIT_DONE case: no i_tx_done after the byte. Response: o_err pulse 16 cycles later, grant released, next requester served.
  - LOCK_STALL case: locked req1 drops v mid-packet. Response: o_err after 16 cycles.
- Reset mid-packet:
  - Stimulus: rst=0 for 1 cycle in WAIT_DONE.
  - Response: all outputs 0, IDLE, requester 0 has priority next.
